// File: rtl/rv32_pipe_pkg.sv
// Shared definitions for the RV32 5-stage pipeline control slice.
//   NOP_INSTR     : canonical bubble encoding (addi x0, x0, 0)
//   XLEN_DEFAULT  : default datapath / PC width
//   REG_X0        : architectural zero register index
//   ctrl_state_t  : hazard sequencer state (RUN / REDIR_PEND)
package rv32_pipe_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [4:0]  REG_X0       = 5'd0;

    // Two bits wide so that a corrupted register value is representable and
    // can be steered back to RUN.
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        REDIR_PEND = 2'd1
    } ctrl_state_t;

endpackage

// File: rtl/lu_hazard_det.sv
// Load-use hazard detector.
// Flags when the load in EX writes a register that the instruction in ID
// actually reads. Writes to x0 never create a dependency.
//   idex_mem_read         : instruction in EX is a load
//   idex_rd               : destination register of the EX instruction
//   ifid_rs1 / ifid_rs2   : source registers of the ID instruction
//   ifid_use_rs1 / _rs2   : ID instruction reads rs1 / rs2
//   lu                    : load-use hazard present
module lu_hazard_det
    import rv32_pipe_pkg::*;
(
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rd,
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    input  logic       ifid_use_rs1,
    input  logic       ifid_use_rs2,
    output logic       lu
);

    logic hit_rs1;
    logic hit_rs2;

    assign hit_rs1 = ifid_use_rs1 && (idex_rd == ifid_rs1);
    assign hit_rs2 = ifid_use_rs2 && (idex_rd == ifid_rs2);
    assign lu      = idex_mem_read && (idex_rd != REG_X0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline.
// Drives the enables and flushes of the PC and the pipeline registers,
// arbitrating (highest first) data-memory wait, EX branch redirect,
// load-use hazard and instruction-fetch wait. A redirect that fetch cannot
// accept is parked in REDIR_PEND until fetch is ready.
// All control outputs are combinational from state and inputs; only the
// state, the parked target and the two performance counters are registered.
//   clk, rst                : clock, synchronous active-high reset
//   imem_ready              : fetch port accepts a PC this cycle
//   dmem_req_mem/dmem_ready : MEM-stage access present / completing
//   ex_branch_taken/ex_target : EX redirect request and target
//   idex_*, ifid_*          : operand info for load-use detection
//   pc_en, pc_redirect, redirect_pc_o : PC load enable, mux select, target
//   ifid_en, idex_en, exmem_en        : stage register enables
//   ifid_flush, idex_flush, memwb_flush : bubble insertion
//   stall_cnt, flush_cnt    : cycles with pc_en=0, committed redirects
module pipe_hazard_ctrl
    import rv32_pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_ready,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    input  logic             ex_branch_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_t     state;
    ctrl_state_t     state_nxt;
    logic [XLEN-1:0] pend_pc;
    logic [XLEN-1:0] pend_pc_nxt;
    logic            dstall;
    logic            lu;
    logic            commit;

    assign dstall = dmem_req_mem && !dmem_ready;

    lu_hazard_det u_lu (
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .ifid_use_rs1  (ifid_use_rs1),
        .ifid_use_rs2  (ifid_use_rs2),
        .lu            (lu)
    );

    always_comb begin
        pc_en         = 1'b1;
        pc_redirect   = 1'b0;
        redirect_pc_o = '0;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        memwb_flush   = 1'b0;
        commit        = 1'b0;
        state_nxt     = state;
        pend_pc_nxt   = pend_pc;

        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
            state_nxt   = RUN;
            pend_pc_nxt = '0;
        end else begin
            case (state)
                RUN: begin
                    if (dstall) begin
                        // Freeze everything up to MEM; a branch in EX waits.
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_en    = 1'b0;
                        memwb_flush = 1'b1;
                    end else if (ex_branch_taken) begin
                        // Younger instructions are squashed, so lu is moot.
                        ifid_flush    = 1'b1;
                        idex_flush    = 1'b1;
                        pc_redirect   = 1'b1;
                        redirect_pc_o = ex_target;
                        if (imem_ready) begin
                            commit = 1'b1;
                        end else begin
                            pc_en       = 1'b0;
                            pend_pc_nxt = ex_target;
                            state_nxt   = REDIR_PEND;
                        end
                    end else if (lu) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end else if (!imem_ready) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                    end
                end
                REDIR_PEND: begin
                    pc_redirect   = 1'b1;
                    redirect_pc_o = pend_pc;
                    ifid_flush    = 1'b1;
                    if (dstall) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_en    = 1'b0;
                        memwb_flush = 1'b1;
                    end else if (imem_ready) begin
                        commit    = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        pc_en = 1'b0;
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pend_pc   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pend_pc <= pend_pc_nxt;
            if (!pc_en) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (commit) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ready, dmem_req_mem, dmem_ready, ex_branch_taken;
    logic [31:0] ex_target;
    logic        idex_mem_read;
    logic [4:0]  idex_rd, ifid_rs1, ifid_rs2;
    logic        ifid_use_rs1, ifid_use_rs2;

    logic        pc_en, pc_redirect, ifid_en, idex_en, exmem_en;
    logic        ifid_flush, idex_flush, memwb_flush;
    logic [31:0] redirect_pc_o, stall_cnt, flush_cnt;

    logic        w_pc_en, w_pc_redirect, w_ifid_en, w_idex_en, w_exmem_en;
    logic        w_ifid_flush, w_idex_flush, w_memwb_flush;
    logic [31:0] w_redirect_pc_o;
    logic [3:0]  w_stall_cnt, w_flush_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .imem_ready(imem_ready), .dmem_req_mem(dmem_req_mem),
        .dmem_ready(dmem_ready), .ex_branch_taken(ex_branch_taken), .ex_target(ex_target),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .ifid_rs1(ifid_rs1),
        .ifid_rs2(ifid_rs2), .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .pc_en(pc_en), .pc_redirect(pc_redirect), .redirect_pc_o(redirect_pc_o),
        .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter instance for the wrap-around behaviour.
    pipe_hazard_ctrl #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .imem_ready(imem_ready), .dmem_req_mem(dmem_req_mem),
        .dmem_ready(dmem_ready), .ex_branch_taken(ex_branch_taken), .ex_target(ex_target),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .ifid_rs1(ifid_rs1),
        .ifid_rs2(ifid_rs2), .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .pc_en(w_pc_en), .pc_redirect(w_pc_redirect), .redirect_pc_o(w_redirect_pc_o),
        .ifid_en(w_ifid_en), .idex_en(w_idex_en), .exmem_en(w_exmem_en),
        .ifid_flush(w_ifid_flush), .idex_flush(w_idex_flush), .memwb_flush(w_memwb_flush),
        .stall_cnt(w_stall_cnt), .flush_cnt(w_flush_cnt)
    );

    // ---------------- behavioural reference ----------------
    bit          m_pend;
    logic [31:0] m_pend_pc;
    int unsigned m_stall, m_flush;

    typedef struct packed {
        logic [7:0]  ctl;   // pc_en,pc_redirect,ifid_en,idex_en,exmem_en,ifid_flush,idex_flush,memwb_flush
        logic [31:0] rpc;
        logic        commit;
        logic        park;
    } exp_t;

    function automatic exp_t model();
        exp_t e;
        bit pe, pr, fe, de, me, ff, df, wf;
        bit dst, hz;
        dst = dmem_req_mem && !dmem_ready;
        hz  = idex_mem_read && idex_rd != 0 &&
              ((ifid_use_rs1 && idex_rd == ifid_rs1) || (ifid_use_rs2 && idex_rd == ifid_rs2));
        {pe, pr, fe, de, me, ff, df, wf} = 8'b1011_1000;
        e = '0;
        if (rst) begin
            {pe, pr, fe, de, me, ff, df, wf} = 8'b0000_0111;
        end else if (dst) begin
            {pe, fe, de, me, wf} = 5'b0000_1;
            if (m_pend) begin pr = 1; ff = 1; e.rpc = m_pend_pc; end
        end else if (m_pend) begin
            pr = 1; ff = 1; e.rpc = m_pend_pc; pe = imem_ready; e.commit = imem_ready;
        end else if (ex_branch_taken) begin
            pr = 1; ff = 1; df = 1; e.rpc = ex_target; pe = imem_ready;
            e.commit = imem_ready; e.park = !imem_ready;
        end else if (hz) begin
            pe = 0; fe = 0; df = 1;
        end else if (!imem_ready) begin
            pe = 0; ff = 1;
        end
        e.ctl = {pe, pr, fe, de, me, ff, df, wf};
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        if (!rst && m_pend && ex_branch_taken)
            $error("FAIL branch_in_pending asserted while a redirect is pending");
        e = model();
        if (rst) begin
            m_pend = 0; m_pend_pc = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e.ctl[7]) m_stall++;
            if (e.commit) begin m_flush++; m_pend = 0; end
            if (e.park) begin m_pend = 1; m_pend_pc = ex_target; end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        exp_t e;
        if (chk_on) begin
            e = model();
            chk("ctl", {24'd0, pc_en, pc_redirect, ifid_en, idex_en, exmem_en,
                        ifid_flush, idex_flush, memwb_flush}, {24'd0, e.ctl});
            chk("redirect_pc", redirect_pc_o, e.rpc);
            chk("stall_cnt", stall_cnt, m_stall);
            chk("flush_cnt", flush_cnt, m_flush);
            chk("stall_cnt4", {28'd0, w_stall_cnt}, m_stall & 32'hF);
            chk("flush_cnt4", {28'd0, w_flush_cnt}, m_flush & 32'hF);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; imem_ready = 1; dmem_req_mem = 0; dmem_ready = 1;
        ex_branch_taken = 0; ex_target = 32'h0;
        idex_mem_read = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
        ifid_use_rs1 = 0; ifid_use_rs2 = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        chk_on = 1;
        #1 chk("rst_ctl", {24'd0, pc_en, pc_redirect, ifid_en, idex_en, exmem_en,
                          ifid_flush, idex_flush, memwb_flush}, 32'h07);
        tick();
        idle();
        tick();
        chk("cnt_after_rst_s", stall_cnt, 0);
        chk("cnt_after_rst_f", flush_cnt, 0);

        // load-use
        idex_mem_read = 1; idex_rd = 5; ifid_rs1 = 5; ifid_use_rs1 = 1;
        #1 chk("lu_stall", {29'd0, pc_en, ifid_en, idex_flush}, 32'b001);
        tick();
        idle();
        #1 chk("lu_release", {29'd0, pc_en, ifid_en, idex_en}, 32'b111);
        chk("lu_stall_cnt", stall_cnt, 1);

        // x0 destination and unused source
        idex_mem_read = 1; idex_rd = 0; ifid_rs1 = 0; ifid_use_rs1 = 1;
        #1 chk("x0_nostall", {31'd0, pc_en}, 1);
        tick();
        idex_mem_read = 1; idex_rd = 7; ifid_rs2 = 7; ifid_use_rs2 = 0; ifid_use_rs1 = 0;
        #1 chk("unused_rs2_nostall", {31'd0, pc_en}, 1);
        tick();
        idle();

        // branch with fetch ready
        ex_branch_taken = 1; ex_target = 32'h0000_0100;
        #1 chk("br_ctl", {27'd0, pc_redirect, pc_en, ifid_flush, idex_flush, memwb_flush}, 32'b11110);
        chk("br_target", redirect_pc_o, 32'h100);
        tick();
        idle();
        chk("br_flush_cnt", flush_cnt, 1);

        // pending redirect
        ex_branch_taken = 1; ex_target = 32'h0000_0200; imem_ready = 0;
        tick();
        ex_branch_taken = 0; ex_target = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            #1 chk("pend_target", redirect_pc_o, 32'h200);
            chk("pend_pc_en", {30'd0, pc_en, pc_redirect}, 32'b01);
            tick();
        end
        chk("pend_stall_cnt", stall_cnt, 4);
        imem_ready = 1;
        #1 chk("pend_commit", {30'd0, pc_en, pc_redirect}, 32'b11);
        tick();
        chk("pend_flush_cnt", flush_cnt, 2);
        #1 chk("pend_back_run", {31'd0, pc_redirect}, 0);

        // priority: dstall over branch over load-use
        dmem_req_mem = 1; dmem_ready = 0; ex_branch_taken = 1; ex_target = 32'h300;
        idex_mem_read = 1; idex_rd = 3; ifid_rs1 = 3; ifid_use_rs1 = 1;
        for (int i = 0; i < 2; i++) begin
            #1 chk("prio_freeze", {26'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_flush, pc_redirect},
                   32'b000010);
            tick();
        end
        dmem_ready = 1;
        #1 chk("prio_fire", {29'd0, pc_redirect, pc_en, idex_flush}, 32'b111);
        chk("prio_target", redirect_pc_o, 32'h300);
        tick();
        idle();
        chk("prio_flush_cnt", flush_cnt, 3);
        chk("prio_stall_cnt", stall_cnt, 6);

        // reset while pending
        ex_branch_taken = 1; ex_target = 32'h400; imem_ready = 0;
        tick();
        ex_branch_taken = 0; rst = 1;
        tick();
        idle();
        #1 chk("rst_pend_run", {31'd0, pc_redirect}, 0);
        chk("rst_pend_stall", stall_cnt, 0);
        chk("rst_pend_flush", flush_cnt, 0);

        // 16 fetch stalls wrap the 4-bit counter
        imem_ready = 0;
        repeat (16) tick();
        chk("wrap4", {28'd0, w_stall_cnt}, 0);
        chk("wrap32", stall_cnt, 16);
        idle();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst             = ($urandom_range(0, 79) == 0);
            imem_ready      = ($urandom_range(0, 3) != 0);
            dmem_req_mem    = $urandom_range(0, 1);
            dmem_ready      = ($urandom_range(0, 2) != 0);
            ex_branch_taken = !m_pend && ($urandom_range(0, 4) == 0);
            ex_target       = $urandom;
            idex_mem_read   = $urandom_range(0, 1);
            idex_rd         = 5'($urandom_range(0, 3));
            ifid_rs1        = 5'($urandom_range(0, 3));
            ifid_rs2        = 5'($urandom_range(0, 3));
            ifid_use_rs1    = $urandom_range(0, 1);
            ifid_use_rs2    = $urandom_range(0, 1);
            tick();
        end

        idle();
        tick();
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
